mc_controller_p: RTL

Parametrised successor to the multi-cycle CPU controller: a Moore/opcode-decoded FSM driving the multi-cycle datapath's mux selects and write enables. Adds a memory ready handshake with wait-state timeout, bne, a generated ALUOp field, a retired-instruction counter and optional precise exceptions. Sits between the instruction register (OpCode/Funct) and the shared multi-cycle datapath.

---
 rtl/mc_controller_p_if.sv | 52 +++++
 rtl/mc_controller_p.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_p_if.sv
// mc_controller_p_if
// Bundles the instruction-register fields, the memory ready handshake and
// every datapath control line driven by mc_controller_p.
//   master : controller side (drives controls, reads OpCode/Funct/mem_ready)
//   slave  : datapath side (drives OpCode/Funct/mem_ready, reads controls)
// Parameters:
//   ALUOP_W : width of ALUOp
//   CNT_W   : width of the retired-instruction counter
interface mc_controller_p_if #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
);
    logic [5:0]         OpCode;
    logic [5:0]         Funct;
    logic               mem_ready;

    logic               PCWrite;
    logic               PCWriteCond;
    logic               BranchNe;
    logic               IorD;
    logic               MemWrite;
    logic               MemRead;
    logic               IRWrite;
    logic               RegWrite;
    logic               ExtOp;
    logic               LuiOp;
    logic               EPCWrite;
    logic [1:0]         MemtoReg;
    logic [1:0]         RegDst;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSource;
    logic [ALUOP_W-1:0] ALUOp;
    logic [1:0]         exc_cause;
    logic [CNT_W-1:0]   ret_count;

    modport master (
        input  OpCode, Funct, mem_ready,
        output PCWrite, PCWriteCond, BranchNe, IorD, MemWrite, MemRead,
               IRWrite, RegWrite, ExtOp, LuiOp, EPCWrite,
               MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource,
               ALUOp, exc_cause, ret_count
    );

    modport slave (
        output OpCode, Funct, mem_ready,
        input  PCWrite, PCWriteCond, BranchNe, IorD, MemWrite, MemRead,
               IRWrite, RegWrite, ExtOp, LuiOp, EPCWrite,
               MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource,
               ALUOp, exc_cause, ret_count
    );
endinterface

// File: rtl/mc_controller_p.sv
// mc_controller_p
// Multi-cycle CPU controller: opcode-decoded FSM producing the mux selects
// and write enables of the shared multi-cycle datapath. Memory states wait
// on mem_ready with a bounded wait counter; legal instructions are counted
// in ret_count.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high; forces all outputs to 0 while high
//   bus   : mc_controller_p_if.master (OpCode/Funct/mem_ready in,
//           datapath controls, exc_cause and ret_count out)
// Parameters:
//   ALUOP_W  : ALUOp width (>= 3, upper bits driven 0)
//   WAIT_MAX : cycles allowed in one memory state before timeout (>= 2)
//   CNT_W    : retired-instruction counter width
// Build option:
//   MC_CTRL_EXCEPTION_EN : enables the EXC state, EPCWrite, exc_cause,
//   illegal-opcode trap and memory timeout. When undefined, illegal
//   opcodes return to IF and memory waits are unbounded.
//
// state | meaning
// ------+-----------------------------------------------------------
// IF    | instruction fetch, waits for mem_ready, PC += 4
// ID    | decode, branch target computed into ALUOut
// EX    | execute / address calc / branch / jump completion
// MEM   | data access for lw/sw, waits for mem_ready
// WB    | register file write-back
// EXC   | one-cycle trap: save EPC, jump to vector
module mc_controller_p #(
    parameter int ALUOP_W  = 4,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    mc_controller_p_if.master  bus
);

    localparam int WCNT_W = $clog2(WAIT_MAX);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_MAX - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_EXC = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   ret_q, ret_d;
`ifdef MC_CTRL_EXCEPTION_EN
    logic [1:0]         cause_q, cause_d;
`endif

    logic       is_rtype, is_jr, is_jalr, is_shift;
    logic       is_iarith, is_lw, is_sw, is_branch, is_jump, is_legal;
    logic       mem_wait;
    logic [2:0] alu_op;

    always_comb begin
        is_rtype  = (bus.OpCode == OP_RTYPE);
        is_jr     = is_rtype && (bus.Funct == FN_JR);
        is_jalr   = is_rtype && (bus.Funct == FN_JALR);
        is_shift  = (bus.Funct == FN_SLL) || (bus.Funct == FN_SRL) ||
                    (bus.Funct == FN_SRA);
        is_iarith = (bus.OpCode == OP_ADDI)  || (bus.OpCode == OP_ADDIU) ||
                    (bus.OpCode == OP_ANDI)  || (bus.OpCode == OP_SLTI)  ||
                    (bus.OpCode == OP_SLTIU) || (bus.OpCode == OP_LUI);
        is_lw     = (bus.OpCode == OP_LW);
        is_sw     = (bus.OpCode == OP_SW);
        is_branch = (bus.OpCode == OP_BEQ) || (bus.OpCode == OP_BNE);
        is_jump   = (bus.OpCode == OP_J) || (bus.OpCode == OP_JAL);
        is_legal  = is_rtype || is_iarith || is_lw || is_sw ||
                    is_branch || is_jump;
    end

    always_comb begin
        state_d          = state_q;
        wcnt_d           = '0;
        ret_d            = ret_q;
`ifdef MC_CTRL_EXCEPTION_EN
        cause_d          = cause_q;
`endif
        mem_wait         = 1'b0;
        alu_op           = 3'd0;

        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.BranchNe     = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.MemRead      = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.ExtOp        = 1'b0;
        bus.LuiOp        = 1'b0;
        bus.EPCWrite     = 1'b0;
        bus.MemtoReg     = 2'd0;
        bus.RegDst       = 2'd0;
        bus.ALUSrcA      = 2'd0;
        bus.ALUSrcB      = 2'd0;
        bus.PCSource     = 2'd0;
        bus.exc_cause    = 2'd0;
        bus.ret_count    = '0;

        // Outputs are held at 0 for the whole reset window, whatever the
        // state register holds.
        if (!reset) begin
            bus.ret_count = ret_q;
            unique case (state_q)
                S_IF: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'd1;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                    if (bus.mem_ready) state_d = S_ID;
                    else               mem_wait = 1'b1;
                end
                S_ID: begin
                    bus.ALUSrcB = 2'd3;
                    bus.ExtOp   = 1'b1;
                    if (is_legal) begin
                        state_d = S_EX;
                    end else begin
`ifdef MC_CTRL_EXCEPTION_EN
                        state_d = S_EXC;
                        cause_d = 2'd1;
`else
                        state_d = S_IF;
`endif
                    end
                end
                S_EX: begin
                    state_d = S_IF;
                    if (is_jr || is_jalr) begin
                        // Target comes from rs through the ALU pass path.
                        bus.PCWrite = 1'b1;
                        bus.ALUSrcA = 2'd1;
                        if (is_jalr) begin
                            bus.RegWrite = 1'b1;
                            bus.RegDst   = 2'd1;
                            bus.MemtoReg = 2'd2;
                        end
                        ret_d = ret_q + CNT_W'(1);
                    end else if (is_rtype) begin
                        // Shifts take shamt on operand A.
                        bus.ALUSrcA = is_shift ? 2'd2 : 2'd1;
                        alu_op      = 3'd2;
                        state_d     = S_WB;
                    end else if (is_iarith) begin
                        bus.ALUSrcA = 2'd1;
                        bus.ALUSrcB = 2'd2;
                        bus.ExtOp   = (bus.OpCode != OP_ANDI);
                        bus.LuiOp   = (bus.OpCode == OP_LUI);
                        unique case (bus.OpCode)
                            OP_ANDI:  alu_op = 3'd3;
                            OP_SLTI:  alu_op = 3'd4;
                            OP_SLTIU: alu_op = 3'd5;
                            default:  alu_op = 3'd0;
                        endcase
                        state_d = S_WB;
                    end else if (is_lw || is_sw) begin
                        bus.ALUSrcA = 2'd1;
                        bus.ALUSrcB = 2'd2;
                        bus.ExtOp   = 1'b1;
                        state_d     = S_MEM;
                    end else if (is_branch) begin
                        bus.PCWriteCond = 1'b1;
                        bus.BranchNe    = (bus.OpCode == OP_BNE);
                        bus.ALUSrcA     = 2'd1;
                        bus.PCSource    = 2'd1;
                        alu_op          = 3'd1;
                        ret_d           = ret_q + CNT_W'(1);
                    end else if (is_jump) begin
                        bus.PCWrite  = 1'b1;
                        bus.PCSource = 2'd2;
                        if (bus.OpCode == OP_JAL) begin
                            bus.RegWrite = 1'b1;
                            bus.RegDst   = 2'd2;
                            bus.MemtoReg = 2'd2;
                        end
                        ret_d = ret_q + CNT_W'(1);
                    end
                end
                S_MEM: begin
                    bus.IorD     = 1'b1;
                    bus.MemRead  = is_lw;
                    bus.MemWrite = is_sw;
                    if (bus.mem_ready) begin
                        state_d = is_lw ? S_WB : S_IF;
                        if (is_sw) ret_d = ret_q + CNT_W'(1);
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                S_WB: begin
                    bus.RegWrite = 1'b1;
                    if (is_rtype) begin
                        bus.RegDst   = 2'd1;
                        bus.MemtoReg = 2'd1;
                    end else if (!is_lw) begin
                        bus.MemtoReg = 2'd1;
                    end
                    state_d = S_IF;
                    ret_d   = ret_q + CNT_W'(1);
                end
                S_EXC: begin
`ifdef MC_CTRL_EXCEPTION_EN
                    bus.PCWrite   = 1'b1;
                    bus.PCSource  = 2'd3;
                    bus.EPCWrite  = 1'b1;
                    bus.exc_cause = cause_q;
`endif
                    state_d = S_IF;
                end
                default: state_d = S_IF;
            endcase

            // Wait counter only advances while a memory state stalls; any
            // state change leaves wcnt_d at 0 so IF/MEM always start fresh.
            if (mem_wait) begin
                if (wcnt_q == WCNT_LAST) begin
`ifdef MC_CTRL_EXCEPTION_EN
                    state_d = S_EXC;
                    cause_d = 2'd2;
`else
                    wcnt_d  = wcnt_q;
`endif
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
        end

        bus.ALUOp = ALUOP_W'(alu_op);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            wcnt_q  <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ret_q   <= ret_d;
        end
    end

`ifdef MC_CTRL_EXCEPTION_EN
    always_ff @(posedge clk) begin
        if (reset) cause_q <= 2'd0;
        else       cause_q <= cause_d;
    end
`endif

endmodule
